// File: rtl/ok_wide_buffered_pipe_out.sv
`default_nettype none
// ============================================================================
// Module   : ok_wide_buffered_pipe_out
// Brief    : DATA_W-bit word FIFO serialised into 16-bit slices for a host
//            pipe-out endpoint, with watermarks, sticky flags and word count.
// Revision : 1.0  initial release
// ============================================================================
module ok_wide_buffered_pipe_out #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 9,
    parameter int AFULL_LVL  = 480,
    parameter int AEMPTY_LVL = 32
) (
    input  logic              ti_clk,
    input  logic              ep_reset,
    input  logic              ep_write,
    input  logic [DATA_W-1:0] ep_datain,
    input  logic              pipe_read,
    output logic [15:0]       pipe_data,
    output logic              ep_full,
    output logic              ep_empty,
    output logic              ep_almost_full,
    output logic              ep_almost_empty,
    output logic [3:0]        ep_status,
    output logic [15:0]       ep_count,
    input  logic              clr_flags,
    output logic              ovf_flag,
    output logic              udf_flag
);

    localparam int c_NSLICE = DATA_W / 16;
    localparam int c_SL_W   = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
    localparam int c_DEPTH  = 2 ** ADDR_W;
    localparam logic [c_SL_W-1:0] c_LAST_SLICE = c_SL_W'(c_NSLICE - 1);
    localparam logic [ADDR_W:0]   c_ONE        = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_head;
    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic [ADDR_W:0]   r_count;
    logic [c_SL_W-1:0] r_slice;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic [3:0]        r_status;
    logic [15:0]       r_cnt16;
    logic              r_ovf;
    logic              r_udf;

    logic              w_ptr_full;
    logic              w_ptr_empty;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_pop;
    logic              w_head_byp;
    logic [ADDR_W:0]   w_rptr_nxt;
    logic [ADDR_W:0]   w_count_nxt;
    logic [ADDR_W:0]   w_cnt_sh;
    logic [31:0]       w_cnt32;

    assign w_ptr_empty = (r_wptr == r_rptr);
    assign w_ptr_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                         (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);

    // Write acceptance looks only at the current fullness; a same-cycle pop
    // never frees space for it.
    assign w_wr_ok = ep_write && !w_ptr_full;
    assign w_rd_ok = pipe_read && !w_ptr_empty;
    assign w_pop   = w_rd_ok && (r_slice == c_LAST_SLICE);

    assign w_rptr_nxt = w_pop ? (r_rptr + c_ONE) : r_rptr;

    // The incoming word becomes the head directly when nothing else remains.
    assign w_head_byp = w_wr_ok && (w_ptr_empty || (w_pop && (r_count == c_ONE)));

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_ok && !w_pop) begin
            w_count_nxt = r_count + c_ONE;
        end else if (!w_wr_ok && w_pop) begin
            w_count_nxt = r_count - c_ONE;
        end
    end

    assign w_cnt_sh = w_count_nxt >> (ADDR_W - 4);
    assign w_cnt32  = {{(31 - ADDR_W){1'b0}}, w_count_nxt};

    always_ff @(posedge ti_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr[ADDR_W-1:0]] <= ep_datain;
        end
    end

    // Head prefetch: the word at the next read pointer is loaded every cycle
    // so the following word is ready the cycle after the last slice pops.
    always_ff @(posedge ti_clk or posedge ep_reset) begin
        if (ep_reset) begin
            r_head <= '0;
        end else if (w_head_byp) begin
            r_head <= ep_datain;
        end else begin
            r_head <= r_mem[w_rptr_nxt[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge ti_clk or posedge ep_reset) begin
        if (ep_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_slice <= '0;
        end else begin
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            if (w_wr_ok) begin
                r_wptr <= r_wptr + c_ONE;
            end
            if (w_pop) begin
                r_slice <= '0;
            end else if (w_rd_ok) begin
                r_slice <= r_slice + c_SL_W'(1);
            end
        end
    end

    always_ff @(posedge ti_clk or posedge ep_reset) begin
        if (ep_reset) begin
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_status <= 4'h0;
            r_cnt16  <= 16'h0000;
        end else begin
            r_full   <= (w_cnt32 == 32'(c_DEPTH));
            r_empty  <= (w_cnt32 == 32'd0);
            r_afull  <= (w_cnt32 >= 32'(AFULL_LVL));
            r_aempty <= (w_cnt32 <= 32'(AEMPTY_LVL));
            r_status <= (w_cnt_sh > (ADDR_W + 1)'(15)) ? 4'hF : w_cnt_sh[3:0];
            r_cnt16  <= (w_cnt32 > 32'h0000_FFFF) ? 16'hFFFF : w_cnt32[15:0];
        end
    end

    // Sticky flags: a set event in the same cycle overrides the clear.
    always_ff @(posedge ti_clk or posedge ep_reset) begin
        if (ep_reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (ep_write && w_ptr_full) begin
                r_ovf <= 1'b1;
            end else if (clr_flags) begin
                r_ovf <= 1'b0;
            end
            if (pipe_read && w_ptr_empty) begin
                r_udf <= 1'b1;
            end else if (clr_flags) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign pipe_data       = r_empty ? 16'h0000 : r_head[16*r_slice +: 16];
    assign ep_full         = r_full;
    assign ep_empty        = r_empty;
    assign ep_almost_full  = r_afull;
    assign ep_almost_empty = r_aempty;
    assign ep_status       = r_status;
    assign ep_count        = r_cnt16;
    assign ovf_flag        = r_ovf;
    assign udf_flag        = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_ok_wide_buffered_pipe_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_ok_wide_buffered_pipe_out
// Brief    : Directed scoreboard bench for ok_wide_buffered_pipe_out
//            (64-bit words, 16-entry FIFO).
// Revision : 1.0  initial release
// ============================================================================
module tb_ok_wide_buffered_pipe_out;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              ti_clk = 1'b0;
    logic              ep_reset = 1'b1;
    logic              ep_write = 1'b0;
    logic [DATA_W-1:0] ep_datain = '0;
    logic              pipe_read = 1'b0;
    logic              clr_flags = 1'b0;
    logic [15:0]       pipe_data;
    logic              ep_full, ep_empty, ep_almost_full, ep_almost_empty;
    logic [3:0]        ep_status;
    logic [15:0]       ep_count;
    logic              ovf_flag, udf_flag;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q [$];

    ok_wide_buffered_pipe_out #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_LVL(12), .AEMPTY_LVL(2)
    ) dut (
        .ti_clk(ti_clk), .ep_reset(ep_reset), .ep_write(ep_write),
        .ep_datain(ep_datain), .pipe_read(pipe_read), .pipe_data(pipe_data),
        .ep_full(ep_full), .ep_empty(ep_empty), .ep_almost_full(ep_almost_full),
        .ep_almost_empty(ep_almost_empty), .ep_status(ep_status),
        .ep_count(ep_count), .clr_flags(clr_flags), .ovf_flag(ovf_flag),
        .udf_flag(udf_flag)
    );

    always #5 ti_clk = ~ti_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every consumed slice is compared against the scoreboard head.
    always @(negedge ti_clk) begin
        if (!ep_reset && pipe_read && !ep_empty) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got %0h expected nothing", pipe_data);
            end else begin
                chk("sb_slice", {48'h0, pipe_data}, {48'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge ti_clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] d, input bit accepted);
        ep_write  = 1'b1;
        ep_datain = d;
        if (accepted) begin
            for (int s = 0; s < 4; s++) exp_q.push_back(d[16*s +: 16]);
        end
        tick();
        ep_write = 1'b0;
    endtask

    task automatic rd(input int n);
        pipe_read = 1'b1;
        repeat (n) tick();
        pipe_read = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        ep_reset = 1'b0;
        repeat (5) tick();
        chk("rst_empty", ep_empty, 1);
        chk("rst_aempty", ep_almost_empty, 1);
        chk("rst_status", ep_status, 0);
        chk("rst_pdata", pipe_data, 0);
        chk("rst_full", ep_full, 0);
        chk("rst_count", ep_count, 0);
        chk("rst_flags", {ovf_flag, udf_flag}, 0);

        // Single word, LSB slice first
        wr(64'hDEAD_BEEF_A5A5_1234, 1);
        chk("w1_empty", ep_empty, 0);
        chk("w1_pdata", pipe_data, 16'h1234);
        rd(4);
        chk("w1_drained", ep_empty, 1);

        // Fill to full with watermark checks
        for (int i = 1; i <= DEPTH; i++) begin
            wr({16'(i+3), 16'(i+2), 16'(i+1), 16'(i)} + 64'h1000_2000_3000_4000, 1);
            if (i == 2)  chk("aempty_at2", ep_almost_empty, 1);
            if (i == 3)  chk("aempty_at3", ep_almost_empty, 0);
            if (i == 5)  chk("status_at5", ep_status, 5);
            if (i == 11) chk("afull_at11", ep_almost_full, 0);
            if (i == 12) chk("afull_at12", ep_almost_full, 1);
        end
        chk("full", ep_full, 1);
        chk("full_status", ep_status, 15);
        chk("full_count", ep_count, 16);
        chk("full_ovf0", ovf_flag, 0);
        wr(64'hBAD0_BAD0_BAD0_BAD0, 0);
        chk("ovf_set", ovf_flag, 1);
        chk("ovf_count", ep_count, 16);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("ovf_clr", ovf_flag, 0);
        rd(4 * DEPTH);
        chk("fill_drained", ep_empty, 1);

        // Underflow, and set beats same-cycle clear
        pipe_read = 1'b1;
        clr_flags = 1'b1;
        tick();
        pipe_read = 1'b0;
        clr_flags = 1'b0;
        chk("udf_set", udf_flag, 1);
        chk("udf_count", ep_count, 0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("udf_clr", udf_flag, 0);

        // Simultaneous write and last-slice pop at count 5
        for (int i = 0; i < 5; i++) wr(64'hC0DE_0000_0000_0000 | 64'(i * 17), 1);
        rd(3);
        chk("cnt5_pre", ep_count, 5);
        ep_write  = 1'b1;
        ep_datain = 64'h7777_6666_5555_4444;
        for (int s = 0; s < 4; s++) exp_q.push_back(ep_datain[16*s +: 16]);
        pipe_read = 1'b1;
        tick();
        ep_write  = 1'b0;
        pipe_read = 1'b0;
        chk("cnt5_post", ep_count, 5);
        rd(20);
        chk("cnt5_drained", ep_empty, 1);

        // 3*DEPTH incrementing words across pointer wrap
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 8; k++) begin
                int i;
                i = b * 8 + k;
                wr({16'(4*i+3), 16'(4*i+2), 16'(4*i+1), 16'(4*i)}, 1);
            end
            rd(32);
        end
        chk("wrap_drained", ep_empty, 1);

        // Asynchronous reset mid-word
        wr(64'h1111_2222_3333_4444, 1);
        rd(1);
        #1;
        ep_reset = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_empty", ep_empty, 1);
        chk("arst_pdata", pipe_data, 0);
        chk("arst_count", ep_count, 0);
        tick();
        ep_reset = 1'b0;
        wr(64'h5555_6666_7777_8888, 1);
        chk("arst_slice0", pipe_data, 16'h8888);
        rd(4);
        chk("arst_drained", ep_empty, 1);

        tick();
        chk("sb_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
